// File: rtl/prv664_gpr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : prv664_gpr_pkg
//  Description : Shared types, default sizes and helpers for the multi-port
//                GPR file and its busy scoreboard.
//                Contents: GPR_* default parameters, gpr_index_t / gpr_data_t,
//                GPR_ZERO (hard-wired zero register index), onehot_idx().
//  Revision    : 1.0  initial release
// ============================================================================
package prv664_gpr_pkg;

    localparam int GPR_XLEN = 64;
    localparam int GPR_NREG = 32;
    localparam int GPR_NRD  = 4;
    localparam int GPR_NWR  = 2;
    localparam int GPR_IW   = $clog2(GPR_NREG);

    typedef logic [GPR_IW-1:0]   gpr_index_t;
    typedef logic [GPR_XLEN-1:0] gpr_data_t;

    // Index of the architectural zero register.
    localparam gpr_index_t GPR_ZERO = '0;

    // One-hot decode of a register index; shared by the write-enable decode
    // of the array and the set/clear vectors of the scoreboard so both agree
    // on which register a given index selects.
    function automatic logic [GPR_NREG-1:0] onehot_idx(input gpr_index_t idx);
        logic [GPR_NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage : prv664_gpr_pkg
`default_nettype wire

// File: rtl/gpr_regfile_mp_if.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_regfile_mp_if
//  Description : Bundle of read, writeback and scoreboard signals of the
//                multi-port GPR file.
//                master : issue/writeback side (drives indices, data, set, flush)
//                slave  : register file (drives rd_data_o, rd_busy_o)
//                Read port p   : rd_index_i[p*IW +: IW], rd_data_o[p*XLEN +: XLEN]
//                Write port w  : wr_valid_i[w], wr_index_i[w*IW +: IW],
//                                wr_data_i[w*XLEN +: XLEN]
//  Revision    : 1.0  initial release
// ============================================================================
interface gpr_regfile_mp_if
    import prv664_gpr_pkg::*;
#(
    parameter int XLEN = GPR_XLEN,
    parameter int NREG = GPR_NREG,
    parameter int NRD  = GPR_NRD,
    parameter int NWR  = GPR_NWR
);
    localparam int IW = $clog2(NREG);

    logic [NRD*IW-1:0]   rd_index_i;
    logic [NRD*XLEN-1:0] rd_data_o;
    logic [NRD-1:0]      rd_busy_o;

    logic [NWR-1:0]      wr_valid_i;
    logic [NWR*IW-1:0]   wr_index_i;
    logic [NWR*XLEN-1:0] wr_data_i;

    logic                sb_set_valid_i;
    logic [IW-1:0]       sb_set_index_i;
    logic                flush_i;

    modport master (
        output rd_index_i,
        input  rd_data_o,
        input  rd_busy_o,
        output wr_valid_i,
        output wr_index_i,
        output wr_data_i,
        output sb_set_valid_i,
        output sb_set_index_i,
        output flush_i
    );

    modport slave (
        input  rd_index_i,
        output rd_data_o,
        output rd_busy_o,
        input  wr_valid_i,
        input  wr_index_i,
        input  wr_data_i,
        input  sb_set_valid_i,
        input  sb_set_index_i,
        input  flush_i
    );

endinterface : gpr_regfile_mp_if
`default_nettype wire

// File: rtl/gpr_regfile_mp_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_scoreboard
//  Description : One busy bit per register tracking outstanding producers.
//                next busy = (busy & ~clr) | set, flush clears everything and
//                beats a same-cycle set. Register 0 can never become busy.
//  Ports       : clk_i, srst_i      clock, synchronous active-high reset
//                i_set_valid/index  producer allocated at issue
//                i_flush            clear all busy bits
//                i_clr              per-register clear from valid writebacks
//                i_rd_index         read indices, NRD packed
//                o_rd_busy          busy per read port
//  Revision    : 1.0  initial release
// ============================================================================
module gpr_scoreboard
    import prv664_gpr_pkg::*;
#(
    parameter int NREG   = GPR_NREG,
    parameter int NRD    = GPR_NRD,
    parameter int BYPASS = 1
) (
    input  wire logic                         clk_i,
    input  wire logic                         srst_i,
    input  wire logic                         i_set_valid,
    input  wire logic [$clog2(NREG)-1:0]      i_set_index,
    input  wire logic                         i_flush,
    input  wire logic [NREG-1:0]              i_clr,
    input  wire logic [NRD*$clog2(NREG)-1:0]  i_rd_index,
    output logic      [NRD-1:0]               o_rd_busy
);

    localparam int IW = $clog2(NREG);
    localparam logic [NREG-1:0] c_reg0_mask = NREG'(1);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_set;

    // Setting the zero register is dropped so it never reports busy.
    assign w_set = i_set_valid ? (onehot_idx(i_set_index) & ~c_reg0_mask) : '0;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            r_busy <= '0;
        end else if (i_flush) begin
            r_busy <= '0;
        end else begin
            // Set is OR-ed in after the clear: a new producer issued in the
            // same cycle as the old one writes back stays outstanding.
            r_busy <= (r_busy & ~i_clr) | w_set;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd_busy
        logic [IW-1:0] w_idx;
        assign w_idx = i_rd_index[p*IW +: IW];

        if (BYPASS != 0) begin : g_byp
            // A writeback landing this cycle already resolves the hazard.
            assign o_rd_busy[p] = r_busy[w_idx] & ~i_clr[w_idx];
        end else begin : g_nobyp
            assign o_rd_busy[p] = r_busy[w_idx];
        end
    end

endmodule : gpr_scoreboard
`default_nettype wire

// File: rtl/gpr_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_regfile_mp
//  Description : Multi-port integer register file with write-to-read bypass
//                and per-register busy scoreboard for RAW stall detection.
//  Ports       : clk_i   clock
//                srst_i  synchronous reset, active-high
//                bus     gpr_regfile_mp_if.slave: NRD read ports (data+busy),
//                        NWR writeback ports, scoreboard set and flush
//  Revision    : 1.0  initial release
// ============================================================================
module gpr_regfile_mp
    import prv664_gpr_pkg::*;
#(
    parameter int XLEN   = GPR_XLEN,
    parameter int NREG   = GPR_NREG,
    parameter int NRD    = GPR_NRD,
    parameter int NWR    = GPR_NWR,
    parameter int BYPASS = 1
) (
    input  wire logic        clk_i,
    input  wire logic        srst_i,
    gpr_regfile_mp_if.slave  bus
);

    localparam int IW = $clog2(NREG);
    localparam logic [NREG-1:0] c_reg0_mask = NREG'(1);

    logic [XLEN-1:0]            r_regs [NREG];

    // Per-port decoded write hits, zero register already masked off.
    logic [NWR-1:0][NREG-1:0]   w_wr_hit;
    // Per-register merged write enable/data after port priority.
    logic [NREG-1:0]            w_reg_we;
    logic [XLEN-1:0]            w_reg_wd [NREG];

    logic [NRD-1:0][XLEN-1:0]   w_rd_data;
    logic [NRD-1:0]             w_rd_busy;

    for (genvar w = 0; w < NWR; w++) begin : g_wr_dec
        assign w_wr_hit[w] = bus.wr_valid_i[w]
                           ? (onehot_idx(bus.wr_index_i[w*IW +: IW]) & ~c_reg0_mask)
                           : '0;
    end

    // Ports are scanned in ascending order so the highest-numbered port
    // targeting a register overrides the lower ones; the same merged value
    // feeds both the array and the bypass path, keeping them consistent.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_reg_we[i] = 1'b0;
            w_reg_wd[i] = '0;
        end
        for (int w = 0; w < NWR; w++) begin
            for (int i = 0; i < NREG; i++) begin
                if (w_wr_hit[w][i]) begin
                    w_reg_we[i] = 1'b1;
                    w_reg_wd[i] = bus.wr_data_i[w*XLEN +: XLEN];
                end
            end
        end
    end

    // Entry 0 is only ever loaded by reset, so it holds zero permanently.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (w_reg_we[i]) begin
                    r_regs[i] <= w_reg_wd[i];
                end
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [IW-1:0]   w_idx;
        logic [XLEN-1:0] w_data;

        assign w_idx = bus.rd_index_i[p*IW +: IW];

        always_comb begin
            w_data = r_regs[w_idx];
            if ((BYPASS != 0) && w_reg_we[w_idx]) begin
                w_data = w_reg_wd[w_idx];
            end
            if (w_idx == GPR_ZERO) begin
                w_data = '0;
            end
        end

        assign w_rd_data[p] = w_data;
    end

    assign bus.rd_data_o = w_rd_data;
    assign bus.rd_busy_o = w_rd_busy;

    // Writebacks clear exactly the registers they land on this cycle.
    gpr_scoreboard #(
        .NREG   (NREG),
        .NRD    (NRD),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk_i       (clk_i),
        .srst_i      (srst_i),
        .i_set_valid (bus.sb_set_valid_i),
        .i_set_index (bus.sb_set_index_i),
        .i_flush     (bus.flush_i),
        .i_clr       (w_reg_we),
        .i_rd_index  (bus.rd_index_i),
        .o_rd_busy   (w_rd_busy)
    );

endmodule : gpr_regfile_mp
`default_nettype wire

// File: tb/tb_gpr_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpr_regfile_mp
//  Description : Self-checking bench for gpr_regfile_mp (BYPASS=1, 64x32,
//                4 read / 2 write ports). Table of per-cycle vectors with
//                hand-computed outputs, plus zero sweeps and a set/flush
//                sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_gpr_regfile_mp;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int NRD  = 4;
    localparam int NWR  = 2;
    localparam int IW   = 5;

    localparam logic [63:0] c_db = 64'hDEAD_BEEF_0000_0001;

    logic clk;
    logic srst;

    int checks;
    int failures;

    gpr_regfile_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

    gpr_regfile_mp #(
        .XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)
    ) dut (
        .clk_i  (clk),
        .srst_i (srst),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                 rst;
        logic [1:0]           wv;
        logic [1:0][4:0]      wi;
        logic [1:0][63:0]     wd;
        logic [3:0][4:0]      ri;
        logic                 sv;
        logic [4:0]           si;
        logic                 fl;
        logic [3:0][63:0]     ed;
        logic [3:0]           eb;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vt [NVEC];

    function automatic vec_t mk(
        input logic        rst,
        input logic [1:0]  wv,
        input logic [4:0]  wi0, input logic [63:0] wd0,
        input logic [4:0]  wi1, input logic [63:0] wd1,
        input logic [4:0]  r0, r1, r2, r3,
        input logic        sv, input logic [4:0] si, input logic fl,
        input logic [63:0] e0, e1, e2, e3,
        input logic [3:0]  eb
    );
        vec_t v;
        v.rst = rst; v.wv = wv;
        v.wi[0] = wi0; v.wd[0] = wd0; v.wi[1] = wi1; v.wd[1] = wd1;
        v.ri[0] = r0; v.ri[1] = r1; v.ri[2] = r2; v.ri[3] = r3;
        v.sv = sv; v.si = si; v.fl = fl;
        v.ed[0] = e0; v.ed[1] = e1; v.ed[2] = e2; v.ed[3] = e3;
        v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        srst               = 1'b0;
        bus.wr_valid_i     = '0;
        bus.wr_index_i     = '0;
        bus.wr_data_i      = '0;
        bus.rd_index_i     = '0;
        bus.sb_set_valid_i = 1'b0;
        bus.sb_set_index_i = '0;
        bus.flush_i        = 1'b0;
    endtask

    // Read every register on all ports; data and busy must both be zero.
    task automatic sweep_zero(input string tag);
        for (int g = 0; g < NREG / NRD; g++) begin
            @(negedge clk);
            idle_inputs();
            for (int k = 0; k < NRD; k++) begin
                bus.rd_index_i[k*IW +: IW] = 5'(g*NRD + k);
            end
            #1;
            for (int k = 0; k < NRD; k++) begin
                chk($sformatf("%s r%0d data", tag, g*NRD + k),
                    bus.rd_data_o[k*XLEN +: XLEN], 64'd0);
                chk($sformatf("%s r%0d busy", tag, g*NRD + k),
                    64'(bus.rd_busy_o[k]), 64'd0);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        //            rst wv     wi0    wd0          wi1    wd1    r0     r1     r2     r3   sv  si   fl  e0          e1          e2    e3   eb
        vt[0]  = mk(0, 2'b00, 5'd0,  64'h0,       5'd0,  64'h0,  5'd0,  5'd1,  5'd5,  5'd31, 0, 5'd0, 0, 64'h0,      64'h0,      64'h0, 64'h0, 4'b0000);
        // Bypass of a fresh write, then the same value from the array.
        vt[1]  = mk(0, 2'b01, 5'd5,  c_db,        5'd0,  64'h0,  5'd5,  5'd7,  5'd0,  5'd31, 0, 5'd0, 0, c_db,       64'h0,      64'h0, 64'h0, 4'b0000);
        vt[2]  = mk(0, 2'b00, 5'd0,  64'h0,       5'd0,  64'h0,  5'd5,  5'd7,  5'd0,  5'd31, 0, 5'd0, 0, c_db,       64'h0,      64'h0, 64'h0, 4'b0000);
        // Both ports write idx7: port 1 wins in bypass and array.
        vt[3]  = mk(0, 2'b11, 5'd7,  64'h1,       5'd7,  64'h2,  5'd7,  5'd5,  5'd0,  5'd31, 0, 5'd0, 0, 64'h2,      c_db,       64'h0, 64'h0, 4'b0000);
        vt[4]  = mk(0, 2'b00, 5'd0,  64'h0,       5'd0,  64'h0,  5'd7,  5'd5,  5'd0,  5'd31, 0, 5'd0, 0, 64'h2,      c_db,       64'h0, 64'h0, 4'b0000);
        // Zero register: write and set both dropped.
        vt[5]  = mk(0, 2'b01, 5'd0,  64'hFFFF,    5'd0,  64'h0,  5'd0,  5'd0,  5'd0,  5'd0,  1, 5'd0, 0, 64'h0,      64'h0,      64'h0, 64'h0, 4'b0000);
        vt[6]  = mk(0, 2'b00, 5'd0,  64'h0,       5'd0,  64'h0,  5'd0,  5'd0,  5'd0,  5'd0,  0, 5'd0, 0, 64'h0,      64'h0,      64'h0, 64'h0, 4'b0000);
        // Set idx9: not visible this cycle.
        vt[7]  = mk(0, 2'b00, 5'd0,  64'h0,       5'd0,  64'h0,  5'd9,  5'd0,  5'd0,  5'd0,  1, 5'd9, 0, 64'h0,      64'h0,      64'h0, 64'h0, 4'b0000);
        // Write + set idx9 together: clearing write hides busy now, set wins next cycle.
        vt[8]  = mk(0, 2'b01, 5'd9,  64'h99,      5'd0,  64'h0,  5'd9,  5'd0,  5'd0,  5'd0,  1, 5'd9, 0, 64'h99,     64'h0,      64'h0, 64'h0, 4'b0000);
        vt[9]  = mk(0, 2'b00, 5'd0,  64'h0,       5'd0,  64'h0,  5'd9,  5'd0,  5'd0,  5'd0,  0, 5'd0, 0, 64'h99,     64'h0,      64'h0, 64'h0, 4'b0001);
        // Lone write on port 1 clears idx9 in the same cycle.
        vt[10] = mk(0, 2'b10, 5'd0,  64'h0,       5'd9,  64'hAA, 5'd9,  5'd0,  5'd0,  5'd0,  0, 5'd0, 0, 64'hAA,     64'h0,      64'h0, 64'h0, 4'b0000);
        vt[11] = mk(0, 2'b00, 5'd0,  64'h0,       5'd0,  64'h0,  5'd9,  5'd0,  5'd0,  5'd0,  0, 5'd0, 0, 64'hAA,     64'h0,      64'h0, 64'h0, 4'b0000);
        // Set 3,4,5 then flush with a same-cycle set of 6.
        vt[12] = mk(0, 2'b00, 5'd0,  64'h0,       5'd0,  64'h0,  5'd3,  5'd0,  5'd0,  5'd0,  1, 5'd3, 0, 64'h0,      64'h0,      64'h0, 64'h0, 4'b0000);
        vt[13] = mk(0, 2'b00, 5'd0,  64'h0,       5'd0,  64'h0,  5'd3,  5'd0,  5'd0,  5'd0,  1, 5'd4, 0, 64'h0,      64'h0,      64'h0, 64'h0, 4'b0001);
        vt[14] = mk(0, 2'b00, 5'd0,  64'h0,       5'd0,  64'h0,  5'd3,  5'd4,  5'd5,  5'd0,  1, 5'd5, 0, 64'h0,      64'h0,      c_db,  64'h0, 4'b0011);
        vt[15] = mk(0, 2'b00, 5'd0,  64'h0,       5'd0,  64'h0,  5'd3,  5'd4,  5'd5,  5'd6,  1, 5'd6, 1, 64'h0,      64'h0,      c_db,  64'h0, 4'b0111);
        vt[16] = mk(0, 2'b00, 5'd0,  64'h0,       5'd0,  64'h0,  5'd3,  5'd4,  5'd5,  5'd6,  0, 5'd0, 0, 64'h0,      64'h0,      c_db,  64'h0, 4'b0000);
        // Writes with no prior set: data lands, busy stays 0.
        vt[17] = mk(0, 2'b11, 5'd12, 64'h1234,    5'd13, 64'h5678, 5'd12, 5'd13, 5'd9, 5'd7, 0, 5'd0, 0, 64'h1234,   64'h5678,   64'hAA, 64'h2, 4'b0000);
        // Mid-run reset: write and set in the reset cycle are ignored.
        vt[18] = mk(1, 2'b01, 5'd20, 64'h55,      5'd0,  64'h0,  5'd12, 5'd13, 5'd5,  5'd7,  1, 5'd7, 0, 64'h1234,   64'h5678,   c_db,  64'h2, 4'b0000);
        vt[19] = mk(0, 2'b00, 5'd0,  64'h0,       5'd0,  64'h0,  5'd12, 5'd13, 5'd5,  5'd20, 0, 5'd0, 0, 64'h0,      64'h0,      64'h0, 64'h0, 4'b0000);
        vt[20] = mk(0, 2'b00, 5'd0,  64'h0,       5'd0,  64'h0,  5'd7,  5'd9,  5'd0,  5'd0,  0, 5'd0, 0, 64'h0,      64'h0,      64'h0, 64'h0, 4'b0000);

        idle_inputs();
        srst = 1'b1;
        repeat (2) @(posedge clk);

        sweep_zero("reset");

        for (int n = 0; n < NVEC; n++) begin
            @(negedge clk);
            srst               = vt[n].rst;
            bus.wr_valid_i     = vt[n].wv;
            bus.wr_index_i     = vt[n].wi;
            bus.wr_data_i      = vt[n].wd;
            bus.rd_index_i     = vt[n].ri;
            bus.sb_set_valid_i = vt[n].sv;
            bus.sb_set_index_i = vt[n].si;
            bus.flush_i        = vt[n].fl;
            #1;
            for (int p = 0; p < NRD; p++) begin
                chk($sformatf("vec%0d rd%0d data", n, p),
                    bus.rd_data_o[p*XLEN +: XLEN], vt[n].ed[p]);
                chk($sformatf("vec%0d rd%0d busy", n, p),
                    64'(bus.rd_busy_o[p]), 64'(vt[n].eb[p]));
            end
        end

        sweep_zero("midreset");

        // Set idx7 and idx8 together across two cycles, then a plain flush.
        @(negedge clk);
        idle_inputs();
        bus.sb_set_valid_i = 1'b1;
        bus.sb_set_index_i = 5'd7;
        @(negedge clk);
        bus.sb_set_index_i = 5'd8;
        bus.rd_index_i[0 +: IW]  = 5'd7;
        bus.rd_index_i[IW +: IW] = 5'd8;
        #1;
        chk("seq set7 busy", 64'(bus.rd_busy_o[0]), 64'd1);
        chk("seq set8 pending", 64'(bus.rd_busy_o[1]), 64'd0);
        @(negedge clk);
        bus.sb_set_valid_i = 1'b0;
        bus.flush_i        = 1'b1;
        #1;
        chk("seq flush7 before", 64'(bus.rd_busy_o[0]), 64'd1);
        chk("seq flush8 before", 64'(bus.rd_busy_o[1]), 64'd1);
        @(negedge clk);
        bus.flush_i = 1'b0;
        #1;
        chk("seq flush7 after", 64'(bus.rd_busy_o[0]), 64'd0);
        chk("seq flush8 after", 64'(bus.rd_busy_o[1]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_gpr_regfile_mp
`default_nettype wire
